// File: rtl/sd_spi_read_checker.sv
// Compares SD SPI read data against the address-seeded incrementing pattern.
// Reports each sector verdict as a one-cycle error_flag pulse and keeps saturating pass/fail counts.
module sd_spi_read_checker #(
  parameter int SECTOR_BYTES = 512,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rd_start,
  input  logic [31:0]      rd_sec_addr,
  input  logic             rd_data_valid,
  input  logic [7:0]       rd_data,
  input  logic             rd_done,
  output logic             error_flag,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ok_cnt,
  output logic             busy
);

  // Index must hold SECTOR_BYTES+1 and always expose an 8-bit pattern offset.
  localparam int IDX_W = ($clog2(SECTOR_BYTES + 2) > 8) ? $clog2(SECTOR_BYTES + 2) : 8;
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(SECTOR_BYTES);
  localparam logic [IDX_W-1:0] IDX_SAT  = IDX_W'(SECTOR_BYTES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] CODE_DATA = 2'b01;
  localparam logic [1:0] CODE_LEN  = 2'b10;
  localparam logic [1:0] CODE_TMO  = 2'b11;

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  byte_idx_reg;
  logic [7:0]        seed_reg;
  logic              bad_reg;
  logic [1:0]        code_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;

  logic [IDX_W-1:0]  byte_idx_next;
  logic              bad_next;
  logic [1:0]        code_next;
  logic [7:0]        expected_byte;
  logic              finish;

  // Only the low address byte seeds the pattern.
  logic unused_addr;
  assign unused_addr = ^rd_sec_addr[31:8];

  // Evaluation of the current CHECK cycle; the byte arriving with rd_done is counted first.
  always_comb begin
    byte_idx_next = byte_idx_reg;
    bad_next      = bad_reg;
    code_next     = code_reg;
    expected_byte = seed_reg + byte_idx_reg[7:0];
    finish        = 1'b0;

    if (rd_data_valid) begin
      if (byte_idx_reg < IDX_FULL) begin
        if ((rd_data != expected_byte) && !bad_next) begin
          bad_next  = 1'b1;
          code_next = CODE_DATA;
        end
      end else if (!bad_next) begin
        bad_next  = 1'b1;
        code_next = CODE_LEN;
      end
      if (byte_idx_reg != IDX_SAT) begin
        byte_idx_next = byte_idx_reg + 1'b1;
      end
    end

    if (rd_done) begin
      finish = 1'b1;
      if ((byte_idx_next != IDX_FULL) && !bad_next) begin
        bad_next  = 1'b1;
        code_next = CODE_LEN;
      end
    end else if (tmo_cnt_reg == TMO_LAST) begin
      finish = 1'b1;
      if (!bad_next) begin
        bad_next  = 1'b1;
        code_next = CODE_TMO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      byte_idx_reg <= '0;
      seed_reg     <= '0;
      bad_reg      <= 1'b0;
      code_reg     <= '0;
      tmo_cnt_reg  <= '0;
      error_flag   <= 1'b0;
      err_code     <= '0;
      err_cnt      <= '0;
      ok_cnt       <= '0;
      busy         <= 1'b0;
    end else begin
      error_flag <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rd_start) begin
            seed_reg     <= rd_sec_addr[7:0];
            byte_idx_reg <= '0;
            bad_reg      <= 1'b0;
            tmo_cnt_reg  <= '0;
            state_reg    <= CHECK;
            busy         <= 1'b1;
          end
        end
        CHECK: begin
          tmo_cnt_reg  <= tmo_cnt_reg + 1'b1;
          byte_idx_reg <= byte_idx_next;
          bad_reg      <= bad_next;
          code_reg     <= code_next;
          // Verdict outputs are registered here so they are visible during the REPORT cycle.
          if (finish) begin
            state_reg <= REPORT;
            if (bad_next) begin
              error_flag <= 1'b1;
              err_code   <= code_next;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
              end
            end else if (ok_cnt != '1) begin
              ok_cnt <= ok_cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
